decoder38_hold: RTL and testbench



---
 rtl/decoder38_pkg.sv | 32 +++
 rtl/decoder38_hold_timer.sv | 44 ++++
 rtl/decoder38_hold.sv | 140 ++++++++++++++
 tb/tb_decoder38_hold.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/decoder38_pkg.sv
// -----------------------------------------------------------------------------
// decoder38_pkg
// Shared types and constants for the decoder38_hold 3-to-8 sequential decoder.
//   CODE_W / LINE_W : width of the binary code and of the decoded line bus
//   state_t         : controller states (IDLE, HOLD)
//   onehot8()       : binary code -> active-high one-hot pattern
//   IDLE_LINES      : value driven on the line bus while no line is selected
// Configuration macro: DECODER38_ACTIVE_LOW_EN (active-low 74138-style lines,
// idle value 8'hFF). When undefined, lines are active-high with idle 8'h00.
// -----------------------------------------------------------------------------
package decoder38_pkg;

   localparam int CODE_W = 3;
   localparam int LINE_W = 8;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Active-high one-hot pattern for a 3-bit code.
   function automatic logic [LINE_W-1:0] onehot8(input logic [CODE_W-1:0] code);
      return 8'b0000_0001 << code;
   endfunction

`ifdef DECODER38_ACTIVE_LOW_EN
   localparam logic [LINE_W-1:0] IDLE_LINES = 8'hFF;
`else
   localparam logic [LINE_W-1:0] IDLE_LINES = 8'h00;
`endif

endpackage

// File: rtl/decoder38_hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
// Down-counter that times the hold window of one decoded line. A load takes
// priority over counting; counting stops at zero so the value never wraps.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (counter -> 0)
//   load     in   load load_val on this edge
//   load_val in   CNT_W-bit reload value
//   cnt_en   in   decrement by one on this edge (ignored at zero)
//   zero     out  counter currently equals zero
//   count    out  current counter value
// -----------------------------------------------------------------------------
module hold_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             cnt_en,
   output logic             zero,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_r;

   // Counter register: reset, reload, or saturating decrement.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= '0;
      end else if (load) begin
         count_r <= load_val;
      end else if (cnt_en && (count_r != '0)) begin
         count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
   assign zero  = (count_r == '0);

endmodule

// File: rtl/decoder38_hold.sv
// -----------------------------------------------------------------------------
// decoder38_hold
// Sequential 3-to-8 decoder. A code accepted over a valid/ready handshake is
// decoded to a one-hot line that is held on oData for HOLD_CYCLES cycles.
// In the last hold cycle a new code may be accepted for a gapless window;
// otherwise the line is released and oDone pulses for one cycle.
// Parameters:
//   HOLD_CYCLES  cycles each line stays asserted (1..255)
//   CNT_W        hold counter width, 2**CNT_W > HOLD_CYCLES
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   iValid  in   iData is presented this cycle
//   iData   in   3-bit code to decode
//   iReady  out  code is accepted this cycle (combinational from state)
//   oData   out  registered decoded lines Y7..Y0
//   oValid  out  registered, high while a line is held
//   oDone   out  registered one-cycle pulse when a window ends with no new code
// Configuration macro: DECODER38_ACTIVE_LOW_EN selects active-low lines
// (selected line 0, idle 8'hFF); default build is active-high (idle 8'h00).
// -----------------------------------------------------------------------------
module decoder38_hold
   import decoder38_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iValid,
   input  logic [CODE_W-1:0] iData,
   output logic              iReady,
   output logic [LINE_W-1:0] oData,
   output logic              oValid,
   output logic              oDone
);

   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [LINE_W-1:0] line_r;
   logic [LINE_W-1:0] line_nxt_s;
   logic              valid_r;
   logic              valid_nxt_s;
   logic              done_r;
   logic              done_nxt_s;
   logic              load_s;
   logic              cnt_en_s;
   logic              zero_s;
   logic [CNT_W-1:0]  count_s;
   logic [LINE_W-1:0] sel_lines_s;

   // Polarity mux: the decoded pattern for the incoming code.
`ifdef DECODER38_ACTIVE_LOW_EN
   assign sel_lines_s = ~onehot8(iData);
`else
   assign sel_lines_s = onehot8(iData);
`endif

   // Ready in IDLE, and in HOLD only during the final cycle of the window.
   assign iReady   = (state_r == IDLE) || zero_s;
   assign cnt_en_s = (state_r == HOLD) && (count_s != '0);

   hold_timer #(
      .CNT_W(CNT_W)
   ) u_hold_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (load_s),
      .load_val(RELOAD),
      .cnt_en  (cnt_en_s),
      .zero    (zero_s),
      .count   (count_s)
   );

   // Next-state and next-output logic of the controller.
   always_comb begin
      state_nxt_s = state_r;
      line_nxt_s  = line_r;
      valid_nxt_s = valid_r;
      done_nxt_s  = 1'b0;
      load_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (iValid) begin
               load_s      = 1'b1;
               state_nxt_s = HOLD;
               line_nxt_s  = sel_lines_s;
               valid_nxt_s = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         HOLD: begin
            if (zero_s) begin
               if (iValid) begin
                  // Back-to-back: reload without leaving HOLD, no oDone.
                  load_s      = 1'b1;
                  state_nxt_s = HOLD;
                  line_nxt_s  = sel_lines_s;
                  valid_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = IDLE;
                  line_nxt_s  = IDLE_LINES;
                  valid_nxt_s = 1'b0;
                  done_nxt_s  = 1'b1;
               end
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            line_nxt_s  = IDLE_LINES;
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // State and output registers; reset wins over any in-flight window.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         line_r  <= IDLE_LINES;
         valid_r <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         line_r  <= line_nxt_s;
         valid_r <= valid_nxt_s;
         done_r  <= done_nxt_s;
      end
   end

   assign oData  = line_r;
   assign oValid = valid_r;
   assign oDone  = done_r;

endmodule

// File: tb/tb_decoder38_hold.sv
// -----------------------------------------------------------------------------
// tb_decoder38_hold
// Directed bench for decoder38_hold. Instance a uses HOLD_CYCLES=4, instance b
// uses HOLD_CYCLES=1. Expected line values are hand-computed active-high
// patterns, XORed with POL so the same bench covers DECODER38_ACTIVE_LOW_EN.
// -----------------------------------------------------------------------------
module tb_decoder38_hold;

`ifdef DECODER38_ACTIVE_LOW_EN
   localparam logic [7:0] POL = 8'hFF;
`else
   localparam logic [7:0] POL = 8'h00;
`endif

   logic       clk;
   logic       rst;
   logic       a_ivalid;
   logic [2:0] a_idata;
   logic       a_iready;
   logic [7:0] a_odata;
   logic       a_ovalid;
   logic       a_odone;
   logic       b_ivalid;
   logic [2:0] b_idata;
   logic       b_iready;
   logic [7:0] b_odata;
   logic       b_ovalid;
   logic       b_odone;

   int checks;
   int errors;

   decoder38_hold #(.HOLD_CYCLES(4), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .iValid(a_ivalid), .iData(a_idata),
      .iReady(a_iready), .oData(a_odata), .oValid(a_ovalid), .oDone(a_odone)
   );

   decoder38_hold #(.HOLD_CYCLES(1), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .iValid(b_ivalid), .iData(b_idata),
      .iReady(b_iready), .oData(b_odata), .oValid(b_ovalid), .oDone(b_odone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (a_odata !== POL) begin errors++; $display("FAIL reset_odata got %h exp %h", a_odata, POL); end
      checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got %b exp 0", a_ovalid); end
      checks++; if (a_odone !== 1'b0) begin errors++; $display("FAIL reset_odone got %b exp 0", a_odone); end
      checks++; if (a_iready !== 1'b1) begin errors++; $display("FAIL reset_iready got %b exp 1", a_iready); end
      rst = 1'b0;
      tick();
      checks++; if (a_odata !== POL) begin errors++; $display("FAIL post_reset_odata got %h exp %h", a_odata, POL); end
      checks++; if (b_odata !== POL) begin errors++; $display("FAIL post_reset_b_odata got %h exp %h", b_odata, POL); end
   endtask

   task automatic test_single();
      a_ivalid = 1'b1;
      a_idata  = 3'd5;
      tick();
      a_ivalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (a_odata !== (8'h20 ^ POL)) begin errors++; $display("FAIL single_odata[%0d] got %h exp %h", i, a_odata, 8'h20 ^ POL); end
         checks++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL single_ovalid[%0d] got %b exp 1", i, a_ovalid); end
         checks++; if (a_odone !== 1'b0) begin errors++; $display("FAIL single_odone[%0d] got %b exp 0", i, a_odone); end
         checks++; if (a_iready !== (i == 3)) begin errors++; $display("FAIL single_iready[%0d] got %b exp %b", i, a_iready, (i == 3)); end
         tick();
      end
      checks++; if (a_odata !== POL) begin errors++; $display("FAIL single_release_odata got %h exp %h", a_odata, POL); end
      checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL single_release_ovalid got %b exp 0", a_ovalid); end
      checks++; if (a_odone !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", a_odone); end
      checks++; if (a_iready !== 1'b1) begin errors++; $display("FAIL single_release_iready got %b exp 1", a_iready); end
      tick();
      checks++; if (a_odone !== 1'b0) begin errors++; $display("FAIL single_done_width got %b exp 0", a_odone); end
   endtask

   task automatic test_back_to_back();
      a_ivalid = 1'b1;
      a_idata  = 3'd0;
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++; if (a_odata !== (8'h01 ^ POL)) begin errors++; $display("FAIL b2b_first_odata[%0d] got %h exp %h", i, a_odata, 8'h01 ^ POL); end
         checks++; if (a_odone !== 1'b0) begin errors++; $display("FAIL b2b_first_odone[%0d] got %b exp 0", i, a_odone); end
         if (i == 3) a_idata = 3'd7;
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         checks++; if (a_odata !== (8'h80 ^ POL)) begin errors++; $display("FAIL b2b_second_odata[%0d] got %h exp %h", i, a_odata, 8'h80 ^ POL); end
         checks++; if (a_ovalid !== 1'b1) begin errors++; $display("FAIL b2b_second_ovalid[%0d] got %b exp 1", i, a_ovalid); end
         checks++; if (a_odone !== 1'b0) begin errors++; $display("FAIL b2b_second_odone[%0d] got %b exp 0", i, a_odone); end
         if (i == 3) a_ivalid = 1'b0;
         tick();
      end
      checks++; if (a_odata !== POL) begin errors++; $display("FAIL b2b_release_odata got %h exp %h", a_odata, POL); end
      checks++; if (a_odone !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", a_odone); end
      tick();
   endtask

   task automatic test_ignore_during_hold();
      a_ivalid = 1'b1;
      a_idata  = 3'd6;
      tick();
      a_idata = 3'd2;
      for (int i = 0; i < 3; i++) begin
         checks++; if (a_odata !== (8'h40 ^ POL)) begin errors++; $display("FAIL ignore_odata[%0d] got %h exp %h", i, a_odata, 8'h40 ^ POL); end
         checks++; if (a_iready !== 1'b0) begin errors++; $display("FAIL ignore_iready[%0d] got %b exp 0", i, a_iready); end
         if (i == 2) a_ivalid = 1'b0;
         tick();
      end
      checks++; if (a_odata !== (8'h40 ^ POL)) begin errors++; $display("FAIL ignore_last_odata got %h exp %h", a_odata, 8'h40 ^ POL); end
      tick();
      checks++; if (a_odata !== POL) begin errors++; $display("FAIL ignore_release_odata got %h exp %h", a_odata, POL); end
      checks++; if (a_odone !== 1'b1) begin errors++; $display("FAIL ignore_done got %b exp 1", a_odone); end
      tick();
   endtask

   task automatic test_reset_mid_hold();
      a_ivalid = 1'b1;
      a_idata  = 3'd4;
      tick();
      a_ivalid = 1'b0;
      checks++; if (a_odata !== (8'h10 ^ POL)) begin errors++; $display("FAIL midrst_hold_odata got %h exp %h", a_odata, 8'h10 ^ POL); end
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (a_odata !== POL) begin errors++; $display("FAIL midrst_odata got %h exp %h", a_odata, POL); end
      checks++; if (a_ovalid !== 1'b0) begin errors++; $display("FAIL midrst_ovalid got %b exp 0", a_ovalid); end
      checks++; if (a_odone !== 1'b0) begin errors++; $display("FAIL midrst_odone got %b exp 0", a_odone); end
      checks++; if (a_iready !== 1'b1) begin errors++; $display("FAIL midrst_iready got %b exp 1", a_iready); end
      tick();
      checks++; if (a_odone !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %b exp 0", a_odone); end
      checks++; if (a_odata !== POL) begin errors++; $display("FAIL midrst_idle_odata got %h exp %h", a_odata, POL); end
   endtask

   task automatic test_hold_one();
      logic [7:0] exp_lines [3];
      exp_lines[0] = 8'h02 ^ POL;
      exp_lines[1] = 8'h04 ^ POL;
      exp_lines[2] = 8'h08 ^ POL;
      b_ivalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b_idata = 3'(i + 1);
         checks++; if (b_iready !== 1'b1) begin errors++; $display("FAIL hold1_iready[%0d] got %b exp 1", i, b_iready); end
         tick();
         checks++; if (b_odata !== exp_lines[i]) begin errors++; $display("FAIL hold1_odata[%0d] got %h exp %h", i, b_odata, exp_lines[i]); end
         checks++; if (b_ovalid !== 1'b1) begin errors++; $display("FAIL hold1_ovalid[%0d] got %b exp 1", i, b_ovalid); end
         checks++; if (b_odone !== 1'b0) begin errors++; $display("FAIL hold1_odone[%0d] got %b exp 0", i, b_odone); end
      end
      b_ivalid = 1'b0;
      tick();
      checks++; if (b_odata !== POL) begin errors++; $display("FAIL hold1_release_odata got %h exp %h", b_odata, POL); end
      checks++; if (b_odone !== 1'b1) begin errors++; $display("FAIL hold1_done got %b exp 1", b_odone); end
      tick();
      checks++; if (b_odone !== 1'b0) begin errors++; $display("FAIL hold1_done_width got %b exp 0", b_odone); end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      a_ivalid = 1'b0;
      a_idata  = 3'd0;
      b_ivalid = 1'b0;
      b_idata  = 3'd0;
      #1;
      test_reset();
      test_single();
      test_back_to_back();
      test_ignore_during_hold();
      test_reset_mid_hold();
      test_hold_one();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
